fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Parametrised instruction fetch/sequence controller for the OSECPU core. It fetches variable-length instructions (1..MAX_WORDS words) from instruction memory through a ready-qualified request handshake and presents the assembled instruction to the execute stage. It holds until execute completes, applies taken jumps, and latches halt. It sits between instruction memory and the decode/execute unit and owns the program counter and the control register.

## Interface
- ADDR_WIDTH, 16, program counter / memory address width
- WORD_WIDTH, 32, instruction word width; opcode is bits [WORD_WIDTH-1 -: 8]
- MAX_WORDS, 4, maximum instruction length in words (>=2)

- clk  in  1  single clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- mem_req  out  1  fetch request; memaddr valid while high
- memaddr  out  ADDR_WIDTH  fetch address; equals pc while mem_req, else 0
- memdata  in  WORD_WIDTH  fetched word, sampled on a cycle with mem_req && mem_ready
- mem_ready  in  1  memory has memdata valid this cycle
- instr  out  MAX_WORDS*WORD_WIDTH  assembled instruction; word 0 in the low slice
- instr_len  out  $clog2(MAX_WORDS+1)  word count of the held instruction
- instr_valid  out  1  high in EXEC; instr/instr_len stable while high
- exec_done  in  1  execute stage finished the held instruction (sampled only in EXEC)
- jump_en  in  1  with exec_done: redirect fetch
- jump_addr  in  ADDR_WIDTH  jump target
- pc  out  ADDR_WIDTH  address of the next word to fetch
- current_state  out  2  FETCH=0, EXEC=1, HALTED=2
- cr  out  8  control register: bit BIT_CR_HLT = halted, bit BIT_CR_ERR = length fault

## Operation
- Reset: pc=0, state=FETCH, word index=0, instr=0, instr_len=0, cr=0, instr_valid=0. mem_req is combinational and is high in FETCH, so it is high in the cycle after reset.
- FETCH: mem_req=1, memaddr=pc. On each cycle with mem_ready=1:
  - memdata is stored into word slice [index].
  - pc <= pc+1, wrapping modulo 2^ADDR_WIDTH.
  - If index==0, word slices 1..MAX_WORDS-1 are cleared and the required length is looked up with instr_words(opcode of memdata).
  - When the accepted word is the last one (index==len-1), state goes to EXEC, instr_len=len and index=0. Otherwise index increments.
  - mem_ready=0: nothing changes and the request holds.
- Length fault: if instr_words returns 0 or a value >MAX_WORDS, cr[ERR] and cr[HLT] are set and the state goes to HALTED. pc has already advanced past the faulting word.
- EXEC: instr_valid=1. The state holds until exec_done=1. On that edge:
  - If the opcode is OP_HLT, cr[HLT] is set and the state goes to HALTED. jump_en is ignored.
  - Else if jump_en=1, pc <= jump_addr and the state goes to FETCH.
  - Otherwise the state goes to FETCH with pc unchanged.
- HALTED: mem_req=0, instr_valid=0, all registers frozen. Only reset exits this state.
- Inputs are ignored outside their qualifying state: mem_ready outside FETCH, exec_done/jump_en outside EXEC.

## Timing
- Zero-wait memory (mem_ready tied 1): an n-word instruction takes n FETCH cycles plus at least 1 EXEC cycle. The minimum loop is 2 cycles for a 1-word instruction when exec_done is high on the first EXEC cycle.
- Each memory wait cycle adds exactly one cycle to the fetch.
- A jump takes effect on the next cycle: memaddr=jump_addr in the first FETCH cycle after exec_done.
- When reset is asserted in any state, the reset values above hold on the next edge. Any in-flight fetch is discarded.
- pc wrap: a fetch at pc=2^ADDR_WIDTH-1 leaves pc=0. A multi-word instruction continues fetching from address 0.

## Structure
- Shared package/include holds:
  - state encodings STATE_FETCH/STATE_EXEC/STATE_HALTED
  - opcode constants (OP_LIMM32, OP_HLT, ...)
  - BIT_CR_HLT, BIT_CR_ERR
  - the function instr_words(op) returning word count: OP_LIMM32 -> 2, every other defined op -> 1, undefined -> 0
- Optional sub-module instr_assembler: word-slice storage, index counter and clear logic. All other logic stays flat.

## Test plan
- Zero-wait sequence: mem[0]={OP_LIMM32,24'h0}, mem[1]=32'h12345678, mem[2]={OP_HLT,24'h0}, exec_done=1 throughout -> EXEC with instr_len=2 and slice1=32'h12345678, then HALTED with cr[HLT]=1, pc=3, mem_req=0.
- Wait states: mem_ready low for 3 cycles before each word -> same instr contents, each fetch stretched by 3 cycles, pc advancing only on ready cycles.
- Jump: single-word op at 0, exec_done=1 with jump_en=1 and jump_addr=16'h0040 -> next cycle memaddr=16'h0040.
- EXEC hold: exec_done held low for 5 cycles -> instr_valid stays high, instr stays stable and mem_req stays 0 for all 5 cycles.
- pc wrap: pc preloaded by jump to 16'hFFFF with a LIMM32 there -> second word fetched from address 0, then pc=1.
- Reset mid-fetch after the first word of a LIMM32 -> next cycle pc=0, instr=0, state FETCH. Also: an undefined opcode -> cr[ERR]=1 and cr[HLT]=1, state HALTED.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared encodings for the OSECPU fetch sequencer: FSM states, opcodes,
// control-register bit positions and the opcode-to-length lookup.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    STATE_FETCH  = 2'd0,
    STATE_EXEC   = 2'd1,
    STATE_HALTED = 2'd2
  } state_t;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_LIMM32 = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h10;
  localparam logic [7:0] OP_SUB    = 8'h11;
  localparam logic [7:0] OP_HLT    = 8'hFF;

  localparam int BIT_CR_HLT = 0;
  localparam int BIT_CR_ERR = 1;

  // Word count of an instruction given its opcode; 0 marks an undefined opcode.
  function automatic logic [7:0] instr_words(input logic [7:0] op);
    case (op)
      OP_LIMM32:                      return 8'd2;
      OP_NOP, OP_ADD, OP_SUB, OP_HLT: return 8'd1;
      default:                        return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_sequencer_instr_assembler.sv
// Word-slice storage and word index for the instruction being fetched.
// Starting a new instruction clears every slice above word 0.
module instr_assembler #(
  parameter int WORD_WIDTH = 32,
  parameter int MAX_WORDS  = 4,
  parameter int IDX_W      = $clog2(MAX_WORDS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            accept,
  input  logic                            last,
  input  logic [WORD_WIDTH-1:0]           data,
  output logic [IDX_W-1:0]                index,
  output logic [MAX_WORDS*WORD_WIDTH-1:0] instr
);

  logic [MAX_WORDS-1:0][WORD_WIDTH-1:0] words_q;
  logic [IDX_W-1:0]                     index_q;

  // NOTE: the slices are ordinary flops with a reset because instr must read
  // as zero after reset; this is not a RAM and must not be inferred as one.
  always_ff @(posedge clk) begin
    if (reset) begin
      words_q <= '0;
      index_q <= '0;
    end else if (accept) begin
      for (int i = 0; i < MAX_WORDS; i++) begin
        if (i == int'(index_q))
          words_q[i] <= data;
        else if (index_q == '0)
          words_q[i] <= '0;
      end
      index_q <= last ? '0 : index_q + IDX_W'(1);
    end
  end

  assign index = index_q;
  assign instr = words_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequence controller: fetches variable-length instructions,
// holds them for execute, applies jumps and latches halt / length faults.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_WIDTH = 32,
  parameter int MAX_WORDS  = 4,
  localparam int LEN_W     = $clog2(MAX_WORDS + 1),
  localparam int IDX_W     = $clog2(MAX_WORDS)
) (
  input  logic                            clk,
  input  logic                            reset,
  output logic                            mem_req,
  output logic [ADDR_WIDTH-1:0]           memaddr,
  input  logic [WORD_WIDTH-1:0]           memdata,
  input  logic                            mem_ready,
  output logic [MAX_WORDS*WORD_WIDTH-1:0] instr,
  output logic [LEN_W-1:0]                instr_len,
  output logic                            instr_valid,
  input  logic                            exec_done,
  input  logic                            jump_en,
  input  logic [ADDR_WIDTH-1:0]           jump_addr,
  output logic [ADDR_WIDTH-1:0]           pc,
  output logic [1:0]                      current_state,
  output logic [7:0]                      cr
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]            cr_q, cr_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      instr_len_q, instr_len_d;

  logic                  accept, last, fault;
  logic [IDX_W-1:0]      index;
  logic [7:0]            lookup;
  logic [LEN_W-1:0]      eff_len;

  assign accept  = (state_q == STATE_FETCH) && mem_ready;
  assign lookup  = instr_words(memdata[WORD_WIDTH-1 -: 8]);
  assign fault   = accept && (index == '0) && (lookup == 8'd0 || lookup > 8'(MAX_WORDS));
  // The length is only known from word 0; later words use the latched value.
  assign eff_len = (index == '0) ? lookup[LEN_W-1:0] : len_q;
  assign last    = accept && (fault || LEN_W'(index) == eff_len - LEN_W'(1));

  instr_assembler #(
    .WORD_WIDTH (WORD_WIDTH),
    .MAX_WORDS  (MAX_WORDS),
    .IDX_W      (IDX_W)
  ) u_assembler (
    .clk    (clk),
    .reset  (reset),
    .accept (accept),
    .last   (last),
    .data   (memdata),
    .index  (index),
    .instr  (instr)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= STATE_FETCH;
      pc_q        <= '0;
      cr_q        <= '0;
      len_q       <= '0;
      instr_len_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cr_q        <= cr_d;
      len_q       <= len_d;
      instr_len_q <= instr_len_d;
    end
  end

  // NOTE: every next-state variable is defaulted first so no path leaves one
  // unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cr_d        = cr_q;
    len_d       = len_q;
    instr_len_d = instr_len_q;
    unique case (state_q)
      STATE_FETCH: begin
        if (accept) begin
          pc_d  = pc_q + ADDR_WIDTH'(1);
          len_d = eff_len;
          if (fault) begin
            cr_d[BIT_CR_ERR] = 1'b1;
            cr_d[BIT_CR_HLT] = 1'b1;
            state_d          = STATE_HALTED;
          end else if (last) begin
            instr_len_d = eff_len;
            state_d     = STATE_EXEC;
          end
        end
      end
      STATE_EXEC: begin
        if (exec_done) begin
          if (instr[WORD_WIDTH-1 -: 8] == OP_HLT) begin
            cr_d[BIT_CR_HLT] = 1'b1;
            state_d          = STATE_HALTED;
          end else begin
            if (jump_en) pc_d = jump_addr;
            state_d = STATE_FETCH;
          end
        end
      end
      STATE_HALTED: ;
      default: state_d = STATE_HALTED;
    endcase
  end

  assign mem_req       = (state_q == STATE_FETCH);
  assign memaddr       = mem_req ? pc_q : '0;
  assign instr_valid   = (state_q == STATE_EXEC);
  assign instr_len     = instr_len_q;
  assign pc            = pc_q;
  assign current_state = state_q;
  assign cr            = cr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a behavioural
// instruction memory and hand-computed expectations.
module tb_fetch_sequencer;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_LIMM32 = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h10;
  localparam logic [7:0] OP_HLT    = 8'hFF;
  localparam logic [7:0] OP_UNDEF  = 8'h77;

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_EXEC   = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_req;
  logic [15:0]  memaddr;
  logic [31:0]  memdata;
  logic         mem_ready;
  logic [127:0] instr;
  logic [2:0]   instr_len;
  logic         instr_valid;
  logic         exec_done;
  logic         jump_en;
  logic [15:0]  jump_addr;
  logic [15:0]  pc;
  logic [1:0]   current_state;
  logic [7:0]   cr;

  logic [31:0]  mem [0:65535];
  int           checks   = 0;
  int           failures = 0;

  localparam logic [127:0] LIMM_INSTR = {64'h0, 32'h12345678, OP_LIMM32, 24'h0};

  assign memdata = mem[memaddr];

  fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req       (mem_req),
    .memaddr       (memaddr),
    .memdata       (memdata),
    .mem_ready     (mem_ready),
    .instr         (instr),
    .instr_len     (instr_len),
    .instr_valid   (instr_valid),
    .exec_done     (exec_done),
    .jump_en       (jump_en),
    .jump_addr     (jump_addr),
    .pc            (pc),
    .current_state (current_state),
    .cr            (cr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = {OP_NOP, 24'h0};
    mem[0]      = {OP_LIMM32, 24'h0};
    mem[1]      = 32'h12345678;
    mem[2]      = {OP_HLT, 24'h0};
    mem[5]      = {OP_UNDEF, 24'h0};
    mem[16'h40] = {OP_ADD, 24'h0};
    mem[16'hFFFF] = {OP_LIMM32, 24'h0};

    reset = 1'b1; mem_ready = 1'b1; exec_done = 1'b0; jump_en = 1'b0; jump_addr = 16'h0;
    step(); step();
    reset = 1'b0;

    // Reset state
    check("rst_state", 128'(current_state), 128'(S_FETCH));
    check("rst_pc", 128'(pc), 128'h0);
    check("rst_mem_req", 128'(mem_req), 128'h1);
    check("rst_instr", instr, 128'h0);
    check("rst_cr", 128'(cr), 128'h0);
    check("rst_valid", 128'(instr_valid), 128'h0);
    check("rst_len", 128'(instr_len), 128'h0);

    // Zero-wait LIMM32 then HLT
    exec_done = 1'b1;
    step();
    check("zw_pc1", 128'(pc), 128'h1);
    check("zw_state1", 128'(current_state), 128'(S_FETCH));
    step();
    check("zw_state_exec", 128'(current_state), 128'(S_EXEC));
    check("zw_len", 128'(instr_len), 128'h2);
    check("zw_instr", instr, LIMM_INSTR);
    check("zw_valid", 128'(instr_valid), 128'h1);
    check("zw_req_exec", 128'(mem_req), 128'h0);
    step();
    check("zw_refetch_addr", 128'(memaddr), 128'h2);
    step();
    check("zw_hlt_len", 128'(instr_len), 128'h1);
    check("zw_hlt_slice1_cleared", instr, {96'h0, OP_HLT, 24'h0});
    step();
    check("zw_halted", 128'(current_state), 128'(S_HALTED));
    check("zw_cr", 128'(cr), 128'h1);
    check("zw_pc3", 128'(pc), 128'h3);
    check("zw_req_halted", 128'(mem_req), 128'h0);
    check("zw_addr_halted", 128'(memaddr), 128'h0);
    check("zw_valid_halted", 128'(instr_valid), 128'h0);
    step(); step();
    check("halt_frozen_pc", 128'(pc), 128'h3);
    check("halt_frozen_state", 128'(current_state), 128'(S_HALTED));

    // Wait states: 3 idle cycles before each word
    reset = 1'b1; step(); reset = 1'b0;
    exec_done = 1'b0; mem_ready = 1'b0;
    step(); step(); step();
    check("ws_pc_hold0", 128'(pc), 128'h0);
    check("ws_addr_hold0", 128'(memaddr), 128'h0);
    mem_ready = 1'b1; step(); mem_ready = 1'b0;
    check("ws_pc1", 128'(pc), 128'h1);
    step(); step(); step();
    check("ws_pc_hold1", 128'(pc), 128'h1);
    check("ws_state_hold1", 128'(current_state), 128'(S_FETCH));
    mem_ready = 1'b1; step();
    check("ws_state_exec", 128'(current_state), 128'(S_EXEC));
    check("ws_pc2", 128'(pc), 128'h2);
    check("ws_instr", instr, LIMM_INSTR);
    check("ws_len", 128'(instr_len), 128'h2);

    // EXEC hold with exec_done low; mem_ready high is ignored
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", 128'(instr_valid), 128'h1);
      check("hold_instr", instr, LIMM_INSTR);
      check("hold_req", 128'(mem_req), 128'h0);
      check("hold_pc", 128'(pc), 128'h2);
    end

    // Jump to 0x0040, single-word op there, then jump to 0xFFFF
    exec_done = 1'b1; jump_en = 1'b1; jump_addr = 16'h0040;
    step();
    exec_done = 1'b0; jump_en = 1'b0;
    check("jmp_state", 128'(current_state), 128'(S_FETCH));
    check("jmp_addr", 128'(memaddr), 128'h40);
    step();
    check("add_exec", 128'(current_state), 128'(S_EXEC));
    check("add_pc", 128'(pc), 128'h41);
    check("add_len", 128'(instr_len), 128'h1);
    exec_done = 1'b1; jump_en = 1'b1; jump_addr = 16'hFFFF;
    step();
    exec_done = 1'b0; jump_en = 1'b0;
    check("jmp2_addr", 128'(memaddr), 128'hFFFF);

    // pc wrap across a LIMM32 at 0xFFFF
    step();
    check("wrap_pc0", 128'(pc), 128'h0);
    check("wrap_addr0", 128'(memaddr), 128'h0);
    step();
    check("wrap_exec", 128'(current_state), 128'(S_EXEC));
    check("wrap_pc1", 128'(pc), 128'h1);
    check("wrap_instr", instr, {64'h0, OP_LIMM32, 24'h0, OP_LIMM32, 24'h0});

    // Reset in the middle of a LIMM32 fetch
    reset = 1'b1; step(); reset = 1'b0;
    step();
    check("mid_pc1", 128'(pc), 128'h1);
    check("mid_slice0", instr, {96'h0, OP_LIMM32, 24'h0});
    reset = 1'b1; step(); reset = 1'b0;
    check("mid_rst_pc", 128'(pc), 128'h0);
    check("mid_rst_instr", instr, 128'h0);
    check("mid_rst_state", 128'(current_state), 128'(S_FETCH));

    // Undefined opcode at 5 -> length fault
    step(); step();
    check("uf_exec", 128'(current_state), 128'(S_EXEC));
    exec_done = 1'b1; jump_en = 1'b1; jump_addr = 16'h0005;
    step();
    exec_done = 1'b0; jump_en = 1'b0;
    check("uf_addr", 128'(memaddr), 128'h5);
    step();
    check("uf_state", 128'(current_state), 128'(S_HALTED));
    check("uf_cr", 128'(cr), 128'h3);
    check("uf_pc", 128'(pc), 128'h6);
    exec_done = 1'b1; jump_en = 1'b1;
    step();
    check("uf_frozen_pc", 128'(pc), 128'h6);
    check("uf_frozen_state", 128'(current_state), 128'(S_HALTED));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
